chunk_serial_adder: RTL and testbench
=====================================

Name: chunk_serial_adder

Overview:
- Multi-cycle adder for WIDTH-bit operands.
- Processes one CHUNK-bit slice per clock, LSB slice first, using a ripple full-adder slice. The carry is held in a flop between slices.
- Sits between the operand source and the result consumer. It trades latency for area against the fully combinational ripple adder.
- Single-request start/busy/done handshake. Results are held stable until the next operation completes.

Parameters:
- WIDTH, 12, operand and result width in bits. Must be an integer multiple of CHUNK; any other value is an elaboration error.
- CHUNK, 3, bits added per clock (slice width).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request pulse; sampled only in IDLE
- dina  input  WIDTH  operand A; captured when start is accepted
- dinb  input  WIDTH  operand B; captured when start is accepted
- cin  input  1  carry-in; captured when start is accepted
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out of bit WIDTH-1

Behaviour:
- Reset values (rst high, asynchronous):
  - state=IDLE, chunk index=0, carry flop=0.
  - busy=0, done=0, sum=0, cout=0.
  - Operand and working registers=0.
- NCH = WIDTH/CHUNK. Chunk index counter is ceil(log2(NCH)) bits wide, minimum 1.
- IDLE:
  - busy=0.
  - On an edge with start=1: capture dina, dinb, cin (cin loads the carry flop); index=0; go to RUN.
  - start=0: remain in IDLE.
- RUN:
  - busy=1.
  - Each edge adds dina/dinb slice [index*CHUNK +: CHUNK] plus the carry flop.
  - The slice sum is written into the working register at the same position. The slice carry-out loads the carry flop. index increments.
  - On the edge processing index NCH-1: sum<=final working value including this slice, cout<=slice carry-out, go to DONE.
- DONE:
  - done=1, busy=1 for exactly one cycle.
  - Next edge: go to IDLE, done=0.
- Timing:
  - If start is accepted at edge E, done is high in the cycle following edge E+NCH.
  - The earliest next accept is edge E+NCH+2. Throughput is one operation per NCH+2 cycles.
- Output stability:
  - sum and cout change only on the final RUN edge.
  - They hold their previous values during RUN and until the next completion. Partial slices are never visible on sum.
- start outside IDLE is ignored: no queuing, no effect on the operation in flight. dina/dinb/cin changes after capture have no effect.
- start held high continuously: a new operation is accepted at every IDLE edge, i.e. back-to-back operations at the NCH+2 cadence.
- Wrap-around: result is modulo 2^WIDTH; overflow reported only via cout.
- Reset mid-operation: the operation is abandoned, no done pulse, outputs return to reset values. The first start after rst deasserts is accepted normally.
- Carry chain inside a slice is purely combinational; only the inter-slice carry is registered.

Optional Feature:
- Macro CHUNK_SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output port ovf (output, 1 bit, reset 0).
  - Loaded on the final RUN edge with (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), i.e. two's-complement signed overflow.
  - Holds with the same stability rules as sum/cout.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan (WIDTH=12, CHUNK=3, NCH=4):
- dina=12'hFFF, dinb=12'h001, cin=0, start pulse at edge E -> busy high from E; done high only in the cycle after E+4; sum=12'h000, cout=1.
- dina=12'h123, dinb=12'h456, cin=1 -> sum=12'h57A, cout=0. sum keeps its prior value (12'h000 from the previous test) until the completion edge.
- Accept 12'h0F0+12'h00F; pulse start with 12'hFFF/12'hFFF during RUN -> ignored; result sum=12'h0FF, cout=0; single done pulse.
- Assert rst for 1 cycle during RUN index 2 -> busy=0, done never pulses, sum=0, cout=0. A subsequent start with 12'h800+12'h800, cin=0 -> sum=12'h000, cout=1.
- start held high with constant operands 12'h001+12'h001 -> done pulses every 6 cycles; sum=12'h002 each time.
- With CHUNK_SERIAL_ADDER_OVF_EN:
  - 12'h7FF+12'h001, cin=0 -> sum=12'h800, cout=0, ovf=1.
  - 12'hFFF+12'h001 -> ovf=0.

Source files
------------

// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder: WIDTH-bit adder that handles one CHUNK-bit slice per clock, LSB slice first.
// Latency: accept at edge E; done is high in the cycle after edge E+NCH; one op every NCH+2 cycles.
// Backpressure: start is only sampled in IDLE. start while busy is dropped, and nothing is queued.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start            request pulse, accepted only in IDLE
//   dina, dinb, cin  operands and carry-in, captured when start is accepted
//   busy             high in RUN and DONE
//   done             one-cycle completion pulse
//   sum, cout        registered result, updated only on the final RUN edge
//   ovf              (only with CHUNK_SERIAL_ADDER_OVF_EN) two's-complement signed overflow,
//                    with the same update rule as sum/cout
module chunk_serial_adder #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dina,
  input  logic [WIDTH-1:0] dinb,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  // A width that is not a whole number of slices cannot be processed.
  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("chunk_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  // Partial sums are built up here, so sum never shows a half-finished result.
  logic [WIDTH-1:0] work_q;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] work_nxt;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
  logic             msb_cin;
`endif

  assign a_sl = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign b_sl = b_q[int'(idx_q) * CHUNK +: CHUNK];

  // Ripple through the current slice combinationally. Only the carry that
  // leaves the slice is registered.
  always_comb begin : p_slice
    logic c;
    c         = carry_q;
    slice_sum = '0;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    msb_cin   = 1'b0;
`endif
    for (int i = 0; i < CHUNK; i++) begin
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
      // On the last slice, this is the carry into bit WIDTH-1.
      if (i == CHUNK - 1) msb_cin = c;
`endif
      slice_sum[i] = a_sl[i] ^ b_sl[i] ^ c;
      c            = (a_sl[i] & b_sl[i]) | (c & (a_sl[i] ^ b_sl[i]));
    end
    slice_cout = c;
  end

  // The working value with the current slice merged in. On the final edge it
  // becomes the complete result.
  always_comb begin
    work_nxt = work_q;
    work_nxt[int'(idx_q) * CHUNK +: CHUNK] = slice_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= dina;
            b_q     <= dinb;
            carry_q <= cin;
            idx_q   <= '0;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end else begin
            busy    <= 1'b0;
          end
        end

        ST_RUN: begin
          busy    <= 1'b1;
          work_q  <= work_nxt;
          carry_q <= slice_cout;
          if (idx_q == LAST_IDX) begin
            // The result is published only here, on the final edge.
            sum   <= work_nxt;
            cout  <= slice_cout;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
            ovf   <= msb_cin ^ slice_cout;
`endif
            idx_q <= '0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        ST_DONE: begin
          // A start seen here is ignored. The next accept happens in IDLE.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_serial_adder.sv
module tb_chunk_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] dina;
  logic [11:0] dinb;
  logic        cin;
  logic        busy;
  logic        done;
  logic [11:0] sum;
  logic        cout;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
  logic        ovf;
`endif

  chunk_serial_adder #(.WIDTH(12), .CHUNK(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .dina  (dina),
    .dinb  (dinb),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_done   = 0;
  int   exp_done = 0;
  int   done_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each done pulse pops one expected result from the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      n_done++;
      done_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sum", 32'(sum), 32'(mon_e.s));
        check("cout", 32'(cout), 32'(mon_e.c));
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(mon_e.o));
`endif
        check("busy_with_done", 32'(busy), 32'd1);
      end
    end
  end

  // Drives one start pulse. On return the bench sits at the negedge just
  // after the accepting edge E.
  task automatic issue(input logic [11:0] a, input logic [11:0] b, input logic c,
                       input exp_t e, input bit push);
    @(negedge clk);
    dina  = a;
    dinb  = b;
    cin   = c;
    start = 1'b1;
    if (push) begin
      sb.push_back(e);
      exp_done++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Follows RUN from the negedge after E up to the negedge after E+5.
  // The old result must hold and done must stay low until the final edge.
  // If inject is set, a conflicting start is pulsed while RUN is in progress.
  task automatic watch_run(input logic [11:0] hold_sum, input bit inject);
    for (int k = 0; k < 4; k++) begin
      check("done_early", 32'(done), 32'd0);
      check("busy_run", 32'(busy), 32'd1);
      check("sum_hold", 32'(sum), 32'(hold_sum));
      if (inject && k == 1) begin
        dina  = 12'hFFF;
        dinb  = 12'hFFF;
        cin   = 1'b1;
        start = 1'b1;
      end
      if (inject && k == 2) start = 1'b0;
      @(negedge clk);
    end
    // The monitor checks the result at this negedge (after E+4).
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    dina  = '0;
    dinb  = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;

    // Wrap-around: FFF + 001 = 000 with the carry out.
    issue(12'hFFF, 12'h001, 1'b0, {12'h000, 1'b1, 1'b0}, 1'b1);
    watch_run(12'h000, 1'b0);

    // With carry-in: 123 + 456 + 1 = 57A. The previous sum holds during RUN.
    issue(12'h123, 12'h456, 1'b1, {12'h57A, 1'b0, 1'b0}, 1'b1);
    watch_run(12'h000, 1'b0);

    // A start during RUN is ignored: 0F0 + 00F = 0FF.
    issue(12'h0F0, 12'h00F, 1'b0, {12'h0FF, 1'b0, 1'b0}, 1'b1);
    watch_run(12'h57A, 1'b1);
    check("ignored_start_done_count", 32'(n_done), 32'(exp_done));

    // Reset while index 2 is being processed. The op is abandoned and nothing completes.
    issue(12'h0AB, 12'h0CD, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    issue(12'h800, 12'h800, 1'b0, {12'h000, 1'b1, 1'b1}, 1'b1);
    watch_run(12'h000, 1'b0);

    // start held high: three back-to-back ops at a 6-cycle cadence.
    @(negedge clk);
    dina  = 12'h001;
    dinb  = 12'h001;
    cin   = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back({12'h002, 1'b0, 1'b0});
      exp_done++;
    end
    repeat (13) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    if (done_cyc.size() >= 3) begin
      check("cadence_1", 32'(done_cyc[done_cyc.size()-2] - done_cyc[done_cyc.size()-3]), 32'd6);
      check("cadence_2", 32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 32'd6);
    end else begin
      check("cadence_pulses", 32'(done_cyc.size()), 32'd3);
    end
    check("idle_sum_hold", 32'(sum), 32'h002);

`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    issue(12'h7FF, 12'h001, 1'b0, {12'h800, 1'b0, 1'b1}, 1'b1);
    watch_run(12'h002, 1'b0);
    issue(12'hFFF, 12'h001, 1'b0, {12'h000, 1'b1, 1'b0}, 1'b1);
    watch_run(12'h800, 1'b0);
`endif

    repeat (2) @(negedge clk);
    check("total_done_count", 32'(n_done), 32'(exp_done));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
